es_mul_sequencer: RTL and testbench
===================================

ES_MUL_SEQUENCER -- requirements
Module: es_mul_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of one operand.
REQ-002 SHALL have parameter NUM_INPUTS, default 4, number of operands per operation.
REQ-003 SHALL have parameter CYCLE_W, default 16, width of cycle counter and budget.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  operand vector offered.
REQ-007 in_ready  output  1  block accepts operand vector.
REQ-008 in_data  input  NUM_INPUTS*DATA_WIDTH  operand i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 cycle_budget  input  CYCLE_W  max RUN cycles per operation; 0 = unlimited.
REQ-010 mul_rst  output  1  per-operation clear to es_naive_mul rst.
REQ-011 mul_en  output  1  drives es_naive_mul en.
REQ-012 mul_data  output  NUM_INPUTS x DATA_WIDTH unpacked array  drives es_naive_mul bin_data_in.
REQ-013 mul_result  input  NUM_INPUTS*DATA_WIDTH  from es_naive_mul bin_data_out.
REQ-014 mul_done  input  1  from es_naive_mul done.
REQ-015 out_valid / out_ready  output / input  1 / 1  result handshake.
REQ-016 out_result  output  NUM_INPUTS*DATA_WIDTH  captured product.
REQ-017 out_cycles  output  CYCLE_W  RUN cycles consumed.
REQ-018 out_truncated  output  1  1 = terminated by budget/saturation, not mul_done.

Function
REQ-019 FSM states IDLE, CLEAR, RUN, HOLD; in_ready=1 only in IDLE.
REQ-020 IDLE: in_valid&in_ready latches in_data into mul_data and cycle_budget into internal register -> CLEAR.
REQ-021 CLEAR: exactly one cycle, mul_rst=1, mul_en=0, counter cleared -> RUN.
REQ-022 RUN: mul_rst=0, mul_en=1; counter = 1 in first RUN cycle, +1 each subsequent RUN cycle.
REQ-023 RUN with mul_done=1: capture mul_result, counter, truncated=0 -> HOLD.
REQ-024 RUN with mul_done=0, budget!=0 and counter==budget: capture, truncated=1 -> HOLD.
REQ-025 mul_done and budget match in same cycle: mul_done wins, truncated=0.
REQ-026 Counter reaching all-ones with budget=0: capture, truncated=1 -> HOLD (no wrap).
REQ-027 HOLD: out_valid=1, mul_en=0, mul_rst=1; out_result/out_cycles/out_truncated stable until out_ready.
REQ-028 HOLD with out_ready=1 -> IDLE next cycle; no same-cycle accept (in_ready=0 in HOLD).
REQ-029 Latency: accept at edge T -> CLEAR T+1 -> first RUN T+2; out_valid rises the cycle after capture.
REQ-030 mul_data constant from accept until next accept.
REQ-031 in_data/cycle_budget changes outside IDLE accept have no effect.

Reset
REQ-032 rst=1 at any state -> IDLE next edge, in-flight op discarded.
REQ-033 During/after reset: out_valid=0, out_result=0, out_cycles=0, out_truncated=0, mul_en=0, mul_rst=1, mul_data all 0, counter 0.
REQ-034 in_ready=1 from first cycle with rst=0.

Structure
REQ-035 State enum and CYCLE_W default SHALL live in shared package es_pkg.
REQ-036 Cycle count SHALL use one instance of existing counter (WIDTH=CYCLE_W, STRIDE=1), overflow used for REQ-026.
REQ-037 es_naive_mul SHALL NOT be instantiated inside; connected at top level.

Verification (DATA_WIDTH=8, NUM_INPUTS=4, bench stub raises mul_done after N RUN cycles)
REQ-038 Operands 3,5,7,2, budget 0, N=10, stub result 210 -> out_result=210, out_cycles=10, out_truncated=0; in_ready=0 accept->handshake.
REQ-039 Budget 4, N=10 -> capture on RUN cycle 4, out_cycles=4, out_truncated=1.
REQ-040 Budget 6, N=6 -> out_cycles=6, out_truncated=0.
REQ-041 out_ready low 5 cycles in HOLD -> outputs stable, mul_en=0, in_ready=0; handshake -> IDLE.
REQ-042 rst in RUN cycle 3 -> next cycle out_valid=0, mul_en=0, mul_rst=1; next op 1,1,1,1 N=2 completes correctly.
REQ-043 in_valid held high, two ops -> second accepted cycle after first handshake, one-cycle CLEAR pulse between.

Source files
------------

// File: rtl/es_pkg.sv
// es_pkg: state encoding and default widths shared by the es sequencer family.
package es_pkg;
    localparam int ES_CYCLE_W = 16;
    typedef enum logic [1:0] {ST_IDLE, ST_CLEAR, ST_RUN, ST_HOLD} seq_state_e;
endpackage

// File: rtl/es_mul_sequencer_counter.sv
// es_counter: strided up-counter; clr restarts it, and clr with en restarts at STRIDE.
module es_counter #(
    parameter int WIDTH  = 16,
    parameter int STRIDE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             overflow
);
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH:0]   sum;
    always_comb begin
        sum      = {1'b0, count_q} + (WIDTH+1)'(STRIDE);
        overflow = en & sum[WIDTH];
        count_d  = clr ? (en ? WIDTH'(STRIDE) : '0) : en ? sum[WIDTH-1:0] : count_q;
    end
    always_ff @(posedge clk) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end
    assign count = count_q;
endmodule

// File: rtl/es_mul_sequencer.sv
// es_mul_sequencer: drives an external es_naive_mul through clear/run/hold phases,
// bounding each run by mul_done, a cycle budget or counter saturation.
module es_mul_sequencer
    import es_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_INPUTS = 4,
    parameter int CYCLE_W    = ES_CYCLE_W
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
    input  logic [CYCLE_W-1:0]               cycle_budget,
    output logic                             mul_rst,
    output logic                             mul_en,
    output logic [DATA_WIDTH-1:0]            mul_data [NUM_INPUTS],
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] mul_result,
    input  logic                             mul_done,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [NUM_INPUTS*DATA_WIDTH-1:0] out_result,
    output logic [CYCLE_W-1:0]               out_cycles,
    output logic                             out_truncated
);
    localparam int RW = NUM_INPUTS * DATA_WIDTH;
    seq_state_e            state_q, state_d;
    logic [CYCLE_W-1:0]    budget_q, budget_d, cycles_q, cycles_d, cnt;
    logic [DATA_WIDTH-1:0] mul_data_q [NUM_INPUTS];
    logic [DATA_WIDTH-1:0] mul_data_d [NUM_INPUTS];
    logic [RW-1:0]         result_q, result_d;
    logic                  trunc_q, trunc_d, ovf, hit;
    logic                  in_ready_q, mul_en_q, mul_rst_q, out_valid_q;
    es_counter #(.WIDTH(CYCLE_W), .STRIDE(1)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (state_q == ST_CLEAR),
        .en       (state_q == ST_CLEAR || state_q == ST_RUN),
        .count    (cnt),
        .overflow (ovf)
    );
    always_comb begin
        state_d    = state_q;
        budget_d   = budget_q;
        mul_data_d = mul_data_q;
        result_d   = result_q;
        cycles_d   = cycles_q;
        trunc_d    = trunc_q;
        // mul_done outranks both budget expiry and saturation
        hit        = mul_done | (budget_q != '0 && cnt == budget_q) | (budget_q == '0 && ovf);
        case (state_q)
            ST_IDLE: if (in_valid) begin
                state_d  = ST_CLEAR;
                budget_d = cycle_budget;
                for (int i = 0; i < NUM_INPUTS; i++) mul_data_d[i] = in_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
            ST_CLEAR: state_d = ST_RUN;
            ST_RUN: if (hit) begin
                state_d  = ST_HOLD;
                result_d = mul_result;
                cycles_d = cnt;
                trunc_d  = ~mul_done;
            end
            ST_HOLD: state_d = out_ready ? ST_IDLE : ST_HOLD;
            default: state_d = ST_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            budget_q    <= '0;
            mul_data_q  <= '{default: '0};
            result_q    <= '0;
            cycles_q    <= '0;
            trunc_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            mul_en_q    <= 1'b0;
            mul_rst_q   <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            budget_q    <= budget_d;
            mul_data_q  <= mul_data_d;
            result_q    <= result_d;
            cycles_q    <= cycles_d;
            trunc_q     <= trunc_d;
            in_ready_q  <= state_d == ST_IDLE;
            mul_en_q    <= state_d == ST_RUN;
            mul_rst_q   <= state_d != ST_RUN;
            out_valid_q <= state_d == ST_HOLD;
        end
    end
    assign in_ready      = in_ready_q;
    assign mul_en        = mul_en_q;
    assign mul_rst       = mul_rst_q;
    assign mul_data      = mul_data_q;
    assign out_valid     = out_valid_q;
    assign out_result    = result_q;
    assign out_cycles    = cycles_q;
    assign out_truncated = trunc_q;
endmodule

// File: tb/tb_es_mul_sequencer.sv
// tb_es_mul_sequencer: directed and random operations against a stub multiplier and a reference model.
module tb_es_mul_sequencer;
    localparam int DW = 8;
    localparam int NI = 4;
    localparam int CW = 8;
    localparam int RW = DW * NI;
    logic          clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
    logic          in_ready, mul_rst, mul_en, mul_done, out_valid, out_truncated;
    logic [RW-1:0] in_data = '0, mul_result, out_result, prod;
    logic [CW-1:0] cycle_budget = '0, out_cycles;
    logic [DW-1:0] mul_data [NI];
    int            errors = 0, checks = 0, stub_cnt = 0, n_cur = 1;
    es_mul_sequencer #(.DATA_WIDTH(DW), .NUM_INPUTS(NI), .CYCLE_W(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .cycle_budget(cycle_budget), .mul_rst(mul_rst), .mul_en(mul_en), .mul_data(mul_data),
        .mul_result(mul_result), .mul_done(mul_done), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_cycles(out_cycles), .out_truncated(out_truncated)
    );
    always #5 clk = ~clk;
    // Stub multiplier: done after n_cur enabled cycles; partial result drifts each cycle
    always @(posedge clk) stub_cnt <= mul_rst ? 0 : mul_en ? stub_cnt + 1 : stub_cnt;
    assign prod       = RW'(mul_data[0]) * RW'(mul_data[1]) * RW'(mul_data[2]) * RW'(mul_data[3]);
    assign mul_done   = mul_en && (stub_cnt + 1 == n_cur);
    assign mul_result = prod + (mul_done ? RW'(0) : RW'(stub_cnt + 1));
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    function automatic logic [RW-1:0] ref_prod(input logic [RW-1:0] ops);
        logic [RW-1:0] p = 1;
        for (int i = 0; i < NI; i++) p = p * RW'(ops[i*DW +: DW]);
        return p;
    endfunction
    task automatic run_op(input logic [RW-1:0] ops, input int budget, input int n, input int hold);
        int k, run, lim, exp_cyc;
        bit exp_tr;
        logic [RW-1:0] exp_res;
        lim     = (budget == 0) ? (1 << CW) - 1 : budget;
        exp_cyc = (n <= lim) ? n : lim;
        exp_tr  = n > lim;
        exp_res = ref_prod(ops) + (exp_tr ? RW'(exp_cyc) : RW'(0));
        @(negedge clk);
        n_cur = n; in_data = ops; cycle_budget = CW'(budget); in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 50) begin @(negedge clk); k++; end
        check("accept_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0; in_data = $urandom; cycle_budget = CW'($urandom);
        check("clear_phase", {mul_rst, mul_en, in_ready}, 3'b100);
        run = 0; k = 0;
        @(negedge clk);
        while (!out_valid && k < 400) begin run += int'(mul_en); @(negedge clk); k++; end
        check("out_valid", out_valid, 1);
        check("out_result", out_result, exp_res);
        check("out_cycles", out_cycles, exp_cyc);
        check("out_truncated", out_truncated, exp_tr);
        check("run_latency", run, exp_cyc);
        for (int i = 0; i < NI; i++) check("mul_data", mul_data[i], ops[i*DW +: DW]);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_state", {out_valid, mul_en, mul_rst, in_ready}, 4'b1010);
            check("hold_result", {out_result, out_cycles, out_truncated}, {exp_res, CW'(exp_cyc), exp_tr});
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("handshake_idle", {out_valid, in_ready}, 2'b01);
    endtask
    initial begin
        int k;
        logic [RW-1:0] ops;
        repeat (2) @(negedge clk);
        check("rst_outs", {out_valid, mul_en, mul_rst, out_truncated}, 4'b0010);
        check("rst_result", {out_result, out_cycles}, '0);
        for (int i = 0; i < NI; i++) check("rst_mul_data", mul_data[i], 0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", in_ready, 1);
        run_op(32'h02070503, 0, 10, 1);
        run_op(32'h02070503, 4, 10, 0);
        run_op(32'h02070503, 6, 6, 0);
        run_op(32'h0a0b0c0d, 3, 8, 5);
        run_op(32'h01020304, 0, 300, 0);
        for (int r = 0; r < 8; r++)
            run_op($urandom, int'($urandom_range(0, 12)), int'($urandom_range(1, 14)), int'($urandom_range(0, 3)));
        // Reset in the third RUN cycle discards the operation
        @(negedge clk);
        n_cur = 10; in_data = 32'h09090909; cycle_budget = '0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("run3_en", mul_en, 1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_in_run", {out_valid, mul_en, mul_rst}, 3'b001);
        check("rst_in_run_cycles", out_cycles, 0);
        rst = 1'b0;
        run_op(32'h01010101, 0, 2, 0);
        // Back-to-back operations with in_valid and out_ready held high
        @(negedge clk);
        n_cur = 3; in_data = 32'h01020305; cycle_budget = '0; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_data = 32'h04030201;
        k = 0;
        while (!out_valid && k < 50) begin @(negedge clk); k++; end
        check("b2b_first", out_result, 30);
        @(negedge clk);
        check("b2b_idle", {in_ready, out_valid}, 2'b10);
        @(negedge clk);
        check("b2b_clear", {mul_rst, mul_en, in_ready}, 3'b100);
        @(negedge clk);
        check("b2b_run", {mul_rst, mul_en}, 2'b01);
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 50) begin @(negedge clk); k++; end
        check("b2b_second", {out_valid, out_result, out_cycles}, {1'b1, RW'(24), CW'(3)});
        out_ready = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
